// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU operand-issue slice.
//   DATA_W / REG_ADDR_W / NUM_REGS : datapath and register-file geometry
//   OP_ADD / OP_SUB                : the only opcodes that write back a result
//   OP_NOP                         : opcode driven to the ALU on a bubble
//   FLAG_C / FLAG_V / FLAG_S       : bit positions inside the flags vector
package alu_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned NUM_REGS   = 8;
    localparam int unsigned OP_W       = 4;

    localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0100;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0101;

    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_S = 0;

    // Pipeline tag carried alongside an op: valid, writes-back, destination.
    typedef struct packed {
        logic                  v;
        logic                  w;
        logic [REG_ADDR_W-1:0] rd;
    } stage_tag_t;

    function automatic logic is_writing_op(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 8 x 16 register file, R0 hard-wired to zero.
//   clk, rst                    : clock, synchronous active-high reset (clears all regs)
//   rd_addr_a_i / rd_data_a_o   : combinational read port A
//   rd_addr_b_i / rd_data_b_o   : combinational read port B
//   wb_en_i / wb_addr_i / wb_data_i : writeback write port (wins over load)
//   ld_en_i / ld_addr_i / ld_data_i : external load write port
module alu_regfile
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rd_addr_a_i,
    output logic [DATA_W-1:0]     rd_data_a_o,
    input  logic [REG_ADDR_W-1:0] rd_addr_b_i,
    output logic [DATA_W-1:0]     rd_data_b_o,
    input  logic                  wb_en_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0]     wb_data_i,
    input  logic                  ld_en_i,
    input  logic [REG_ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0]     ld_data_i
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Load is applied first so a same-register writeback overrides it.
    always_comb begin
        regs_d = regs_q;
        if (ld_en_i) begin
            regs_d[ld_addr_i] = ld_data_i;
        end
        if (wb_en_i) begin
            regs_d[wb_addr_i] = wb_data_i;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads see pre-edge contents; same-edge writes are not forwarded here.
    assign rd_data_a_o = (rd_addr_a_i == '0) ? '0 : regs_q[rd_addr_a_i];
    assign rd_data_b_o = (rd_addr_b_i == '0) ? '0 : regs_q[rd_addr_b_i];

endmodule

// File: rtl/alu_operand_issue.sv
// alu_operand_issue: reads operands, issues ops to a one-cycle-latency ALU and writes
// results back two cycles after issue. RAW hazards on the op one stage ahead always
// stall; hazards on the op two stages ahead stall one cycle, or with the optional
// ALU_BYPASS_EN macro defined are resolved by forwarding alu_out_i instead.
//   clk, rst                       : clock, synchronous active-high reset
//   instr_valid_i / instr_ready_o  : instruction handshake
//   instr_op_i/_rd_i/_rs1_i/_rs2_i : opcode, destination and source registers
//   alu_opcode_o / alu_a_o / alu_b_o : registered ALU operands (NOP on bubble)
//   alu_out_i, alu_carry_i, alu_overflow_i, alu_sign_i : ALU results, one cycle after issue
//   ld_en_i / ld_addr_i / ld_data_i : external register-file load
//   wb_valid_o / wb_rd_o / wb_data_o : writeback strobe, destination, value
//   flags_o                        : {carry, overflow, sign} of last writing op
//   busy_o                         : a writing op is in flight
module alu_operand_issue
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic [OP_W-1:0]       instr_op_i,
    input  logic [REG_ADDR_W-1:0] instr_rd_i,
    input  logic [REG_ADDR_W-1:0] instr_rs1_i,
    input  logic [REG_ADDR_W-1:0] instr_rs2_i,
    output logic [OP_W-1:0]       alu_opcode_o,
    output logic [DATA_W-1:0]     alu_a_o,
    output logic [DATA_W-1:0]     alu_b_o,
    input  logic [DATA_W-1:0]     alu_out_i,
    input  logic                  alu_carry_i,
    input  logic                  alu_overflow_i,
    input  logic                  alu_sign_i,
    input  logic                  ld_en_i,
    input  logic [REG_ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0]     ld_data_i,
    output logic                  wb_valid_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic [DATA_W-1:0]     wb_data_o,
    output logic [2:0]            flags_o,
    output logic                  busy_o
);

    stage_tag_t        s1_q, s1_d, s2_q, s2_d;
    logic [OP_W-1:0]   opcode_q, opcode_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]        flags_q, flags_d;

    logic [DATA_W-1:0] rs1_data, rs2_data;
    logic [DATA_W-1:0] op_a, op_b;
    logic              wb_fire;
    logic              s1_writes, s2_writes;
    logic              raw1_a, raw1_b, raw2_a, raw2_b;
    logic              stall, accept;

    // Gated by rst so an op caught in flight by reset never writes back.
    assign s1_writes = s1_q.v & s1_q.w & (s1_q.rd != '0);
    assign s2_writes = s2_q.v & s2_q.w;
    assign wb_fire   = s2_writes & ~rst;

    alu_regfile u_regfile (
        .clk         (clk),
        .rst         (rst),
        .rd_addr_a_i (instr_rs1_i),
        .rd_data_a_o (rs1_data),
        .rd_addr_b_i (instr_rs2_i),
        .rd_data_b_o (rs2_data),
        .wb_en_i     (wb_fire),
        .wb_addr_i   (s2_q.rd),
        .wb_data_i   (alu_out_i),
        .ld_en_i     (ld_en_i),
        .ld_addr_i   (ld_addr_i),
        .ld_data_i   (ld_data_i)
    );

    assign raw1_a = s1_writes & (s1_q.rd == instr_rs1_i);
    assign raw1_b = s1_writes & (s1_q.rd == instr_rs2_i);
    assign raw2_a = s2_writes & (s2_q.rd != '0) & (s2_q.rd == instr_rs1_i);
    assign raw2_b = s2_writes & (s2_q.rd != '0) & (s2_q.rd == instr_rs2_i);

`ifdef ALU_BYPASS_EN
    // The stage-2 result is already on alu_out_i this cycle, so forward it.
    assign stall = raw1_a | raw1_b;
    assign op_a  = raw2_a ? alu_out_i : rs1_data;
    assign op_b  = raw2_b ? alu_out_i : rs2_data;
`else
    // Wait for the stage-2 writeback to land, then read the register file.
    assign stall = raw1_a | raw1_b | raw2_a | raw2_b;
    assign op_a  = rs1_data;
    assign op_b  = rs2_data;
`endif

    assign instr_ready_o = ~rst & ~stall;
    assign accept        = instr_valid_i & instr_ready_o;

    always_comb begin
        s1_d     = '0;
        opcode_d = OP_NOP;
        a_d      = a_q;
        b_d      = b_q;
        s2_d     = s1_q;
        flags_d  = flags_q;
        if (accept) begin
            s1_d.v   = 1'b1;
            s1_d.w   = is_writing_op(instr_op_i);
            s1_d.rd  = instr_rd_i;
            opcode_d = instr_op_i;
            a_d      = op_a;
            b_d      = op_b;
        end
        if (wb_fire) begin
            flags_d[FLAG_C] = alu_carry_i;
            flags_d[FLAG_V] = alu_overflow_i;
            flags_d[FLAG_S] = alu_sign_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            opcode_q <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
            flags_q  <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            opcode_q <= opcode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            flags_q  <= flags_d;
        end
    end

    assign alu_opcode_o = opcode_q;
    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign wb_valid_o   = wb_fire;
    assign wb_rd_o      = s2_q.rd;
    assign wb_data_o    = alu_out_i;
    assign flags_o      = flags_q;
    assign busy_o       = (s1_q.v & s1_q.w) | s2_writes;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue: a behavioural one-cycle ALU, directed stimulus with
// hand-computed writebacks pushed into a scoreboard queue, and a monitor that pops and
// compares whenever wb_valid is seen (value, destination, latency, following flags).
module tb_alu_operand_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [2:0]  instr_rd, instr_rs1, instr_rs2;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_a, alu_b;
    logic [15:0] alu_out = '0;
    logic        alu_carry = 1'b0, alu_overflow = 1'b0, alu_sign = 1'b0;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [2:0]  flags;
    logic        busy;

    localparam logic [3:0] ADD = 4'b0100;
    localparam logic [3:0] SUB = 4'b0101;
    localparam logic [3:0] NOP = 4'b0000;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_accept = 0;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
        logic [2:0]  flg;
        int          cyc;
    } wb_exp_t;
    wb_exp_t exp_q[$];

    logic       flag_chk = 1'b0;
    logic [2:0] flag_exp = '0;

    alu_operand_issue dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid_i  (instr_valid),
        .instr_ready_o  (instr_ready),
        .instr_op_i     (instr_op),
        .instr_rd_i     (instr_rd),
        .instr_rs1_i    (instr_rs1),
        .instr_rs2_i    (instr_rs2),
        .alu_opcode_o   (alu_opcode),
        .alu_a_o        (alu_a),
        .alu_b_o        (alu_b),
        .alu_out_i      (alu_out),
        .alu_carry_i    (alu_carry),
        .alu_overflow_i (alu_overflow),
        .alu_sign_i     (alu_sign),
        .ld_en_i        (ld_en),
        .ld_addr_i      (ld_addr),
        .ld_data_i      (ld_data),
        .wb_valid_o     (wb_valid),
        .wb_rd_o        (wb_rd),
        .wb_data_o      (wb_data),
        .flags_o        (flags),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ALU: carry is carry-out for ADD and borrow for SUB.
    logic [16:0] alu_sum, alu_dif;
    always_comb begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_dif = {1'b0, alu_a} - {1'b0, alu_b};
    end

    always @(posedge clk) begin
        if (alu_opcode == ADD) begin
            alu_out      <= alu_sum[15:0];
            alu_carry    <= alu_sum[16];
            alu_overflow <= (alu_a[15] == alu_b[15]) && (alu_sum[15] != alu_a[15]);
            alu_sign     <= alu_sum[15];
        end else if (alu_opcode == SUB) begin
            alu_out      <= alu_dif[15:0];
            alu_carry    <= alu_dif[16];
            alu_overflow <= (alu_a[15] != alu_b[15]) && (alu_dif[15] != alu_a[15]);
            alu_sign     <= alu_dif[15];
        end else begin
            alu_out      <= '0;
            alu_carry    <= 1'b0;
            alu_overflow <= 1'b0;
            alu_sign     <= 1'b0;
        end
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: flags are checked on the negedge after the writeback edge.
    always @(negedge clk) begin
        if (flag_chk) begin
            check("flags_after_wb", {29'd0, flags}, {29'd0, flag_exp});
            flag_chk = 1'b0;
        end
        if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wb: got rd=%0d data=0x%0h want no writeback",
                         wb_rd, wb_data);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                check("wb_rd", {29'd0, wb_rd}, {29'd0, e.rd});
                check("wb_data", {16'd0, wb_data}, {16'd0, e.data});
                check("wb_latency", cyc, e.cyc);
                flag_chk = 1'b1;
                flag_exp = e.flg;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] r, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = r; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Presents an instruction, counts stall cycles, returns 1 ns after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, output int stalls);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        stalls = 0;
        #1;
        while (!instr_ready && stalls < 8) begin
            stalls++;
            @(posedge clk); #2;
        end
        if (!instr_ready) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got ready=0 after %0d cycles want ready=1", stalls);
            instr_valid = 1'b0;
            #1;
        end else begin
            @(posedge clk); #1;
            instr_valid = 1'b0;
            last_accept = cyc;
        end
    endtask

    task automatic expect_wb(input logic [2:0] rd, input logic [15:0] d, input logic [2:0] f);
        wb_exp_t e;
        e.rd = rd; e.data = d; e.flg = f; e.cyc = last_accept + 1;
        exp_q.push_back(e);
    endtask

    // Reads a register back through the operand path using a non-writing op.
    task automatic peek(input logic [2:0] r, input logic [15:0] exp, input string name);
        int s;
        issue(NOP, 3'd0, r, 3'd0, s);
        check(name, {16'd0, alu_a}, {16'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0;
        instr_rs2 = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        // Reset state
        @(posedge clk); #2;
        check("rst_ready", {31'd0, instr_ready}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_opcode", {28'd0, alu_opcode}, 32'd0);
        check("rst_alu_a", {16'd0, alu_a}, 32'd0);
        check("rst_flags", {29'd0, flags}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("ready_idle", {31'd0, instr_ready}, 32'd1);

        // 0x7FFF + 1 overflows into the sign bit
        load(3'd1, 16'h7FFF);
        load(3'd2, 16'h0001);
        issue(ADD, 3'd3, 3'd1, 3'd2, s);
        expect_wb(3'd3, 16'h8000, 3'b011);
        check("add_stalls", s, 0);
        check("busy_inflight", {31'd0, busy}, 32'd1);
        idle(1);
        check("bubble_opcode", {28'd0, alu_opcode}, 32'd0);
        idle(3);
        peek(3'd3, 16'h8000, "r3_value");

        // Non-writing opcode leaves flags alone
        issue(NOP, 3'd3, 3'd1, 3'd2, s);
        idle(4);
        check("nop_flags_held", {29'd0, flags}, 32'b011);

        // Back-to-back dependent SUB then ADD
        load(3'd1, 16'd5);
        load(3'd2, 16'd7);
        issue(SUB, 3'd4, 3'd1, 3'd2, s);
        expect_wb(3'd4, 16'hFFFE, 3'b101);
        issue(ADD, 3'd5, 3'd4, 3'd4, s);
        expect_wb(3'd5, 16'hFFFC, 3'b101);
`ifdef ALU_BYPASS_EN
        check("raw_chain_stalls", s, 1);
`else
        check("raw_chain_stalls", s, 2);
`endif
        idle(4);
        peek(3'd5, 16'hFFFC, "r5_value");

        // Writeback to R0 pulses but is discarded
        load(3'd1, 16'd3);
        load(3'd2, 16'd4);
        issue(ADD, 3'd0, 3'd1, 3'd2, s);
        expect_wb(3'd0, 16'd7, 3'b000);
        idle(4);
        peek(3'd0, 16'h0000, "r0_zero");

        // Load and writeback collide on R6: writeback wins
        load(3'd1, 16'h1111);
        load(3'd2, 16'h1111);
        issue(ADD, 3'd6, 3'd1, 3'd2, s);
        expect_wb(3'd6, 16'h2222, 3'b000);
        idle(1);
        load(3'd6, 16'h1111);
        idle(3);
        peek(3'd6, 16'h2222, "r6_wb_wins");

        // Stage-2-only hazard, then an independent op at full rate
        load(3'd2, 16'd3);
        issue(ADD, 3'd1, 3'd2, 3'd2, s);
        expect_wb(3'd1, 16'd6, 3'b000);
        issue(NOP, 3'd0, 3'd0, 3'd0, s);
        issue(ADD, 3'd3, 3'd1, 3'd2, s);
        expect_wb(3'd3, 16'd9, 3'b000);
`ifdef ALU_BYPASS_EN
        check("raw2_stalls", s, 0);
`else
        check("raw2_stalls", s, 1);
`endif
        issue(ADD, 3'd4, 3'd2, 3'd2, s);
        expect_wb(3'd4, 16'd6, 3'b000);
        check("indep_stalls", s, 0);
        idle(4);
        peek(3'd3, 16'd9, "r3_bypass_value");

        // Reset the cycle after issuing: op is dropped
        issue(ADD, 3'd7, 3'd2, 3'd2, s);
        rst = 1'b1;
        #1;
        check("ready_in_rst", {31'd0, instr_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("busy_after_rst", {31'd0, busy}, 32'd0);
        idle(4);
        peek(3'd7, 16'h0000, "r7_after_rst");
        peek(3'd2, 16'h0000, "r2_after_rst");

        idle(4);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_issue.md
ALU_OPERAND_ISSUE -- requirements
Module: alu_operand_issue

Interface
REQ-001 Reset rst SHALL be synchronous, active-high; clock clk; all state SHALL update on posedge clk only.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 instr_valid / instr_ready  in / out  1 / 1  instruction handshake; transfer when both are high at posedge.
REQ-005 instr_op / instr_rd / instr_rs1 / instr_rs2  in  4 / 3 / 3 / 3  opcode, destination register, source registers.
REQ-006 alu_opcode / alu_a / alu_b  out  4 / 16 / 16  registered operands to the downstream one-cycle-latency arithmetic ALU.
REQ-007 alu_out / alu_carry / alu_overflow / alu_sign  in  16 / 1 / 1 / 1  registered ALU results, valid one cycle after issue.
REQ-008 ld_en / ld_addr / ld_data  in  1 / 3 / 16  external register-file load port.
REQ-009 wb_valid / wb_rd / wb_data  out  1 / 3 / 16  writeback strobe, destination, value.
REQ-010 flags  out  3  {carry, overflow, sign} from the last arithmetic writeback.
REQ-011 busy  out  1  high while any writing op is in flight.

Function
REQ-012 Opcodes: OP_ADD=4'b0100, OP_SUB=4'b0101 are writing ops; all other opcodes are accepted, issued, and produce no writeback and no flag change.
REQ-013 On accept at edge T: alu_opcode<=instr_op, alu_a<=R[rs1], alu_b<=R[rs2]; stage-1 tag {v1, w1, rd1} loaded.
REQ-014 At edge T+1: stage-2 tag <= stage-1 tag; ALU captures its result.
REQ-015 During cycle T+1..T+2 with v2&w2: wb_valid=1, wb_rd=rd2, wb_data=alu_out; at edge T+2: R[rd2]<=alu_out, flags<={alu_carry, alu_overflow, alu_sign}.
REQ-016 Issue-to-writeback latency SHALL be 2 cycles; throughput 1 op/cycle absent hazards.
REQ-017 With no valid accept, stage-1 tag SHALL become invalid and alu_opcode SHALL be driven 4'b0000 (bubble).
REQ-018 RAW on stage 1 (v1&w1&rd1==rs1 or rs2, rd1!=0): instr_ready=0 for that cycle.
REQ-019 RAW on stage 2 (v2&w2&rd2==rs, rd2!=0): handling per REQ-026/027.
REQ-020 R0 SHALL read 0; writes to R0 (writeback or load) SHALL be discarded; wb_valid still pulses; flags still update.
REQ-021 Load port writes R[ld_addr] at posedge; if writeback targets the same register in the same cycle, writeback SHALL win.
REQ-022 Register reads SHALL observe register contents before same-edge writes, except where bypass applies.
REQ-023 instr_ready SHALL be combinational: !rst & !stall; busy = (v1&w1)|(v2&w2).

Reset
REQ-024 Under rst: v1=v2=0, alu_opcode=0, alu_a=alu_b=0, flags=0, wb_valid=0, instr_ready=0, all registers R0..R7=0.
REQ-025 Reset mid-operation SHALL discard in-flight ops; no writeback SHALL occur for them.

Configuration
REQ-026 With ALU_BYPASS_EN defined: a stage-2 RAW SHALL select alu_out as the operand, with no stall.
REQ-027 Without ALU_BYPASS_EN: a stage-2 RAW SHALL stall one cycle; the operand is read from the register file after writeback.

Structure
REQ-028 Package alu_pkg SHALL hold OP_ADD, OP_SUB, REG_ADDR_W=3, DATA_W=16, and flag bit indices (FLAG_C=2, FLAG_V=1, FLAG_S=0).
REQ-029 Sub-module alu_regfile: 8x16, two combinational read ports, one write port, writeback/load priority mux, R0 read-as-zero.

Verification
REQ-030 Load R1=0x7FFF, R2=0x0001; ADD r3,r1,r2 -> 2 cycles later wb_rd=3, wb_data=0x8000, flags=3'b011.
REQ-031 R1=5, R2=7; SUB r4,r1,r2 then ADD r5,r4,r4 back-to-back -> stall 1 cycle (stage-1 RAW); R5=0xFFFC; with bypass total 1 stall cycle, without bypass 2.
REQ-032 Opcode 4'b0000 issued -> no wb_valid; flags unchanged from the prior value.
REQ-033 ADD r0,r1,r2 with R1=3, R2=4 -> wb_valid=1, R0 still reads 0.
REQ-034 ld_en to R6=0x1111 in the same cycle as writeback to R6=0x2222 -> R6=0x2222.
REQ-035 rst asserted the cycle after issuing ADD r7 -> wb_valid never asserts; R7=0; instr_ready=0 during rst.
